// File: rtl/exc_pkg.sv
// ============================================================================
// Module  : exc_pkg
// Brief   : Shared types and constants for the exception-entry sequencer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package exc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_WAIT = 2'd2,
    ST_LOAD = 2'd3
  } state_t;

  localparam logic [1:0] CAUSE_NONE   = 2'd0;
  localparam logic [1:0] CAUSE_OPCODE = 2'd1;
  localparam logic [1:0] CAUSE_OVF    = 2'd2;
  localparam logic [1:0] CAUSE_DIVZ   = 2'd3;

  localparam logic [2:0] SRCADDR_SEL_IORD = 3'd0;
  localparam logic [2:0] SRCADDR_SEL_V253 = 3'd1;
  localparam logic [2:0] SRCADDR_SEL_V254 = 3'd2;
  localparam logic [2:0] SRCADDR_SEL_V255 = 3'd3;
  localparam logic [2:0] SRCADDR_SEL_A    = 3'd4;
  localparam logic [2:0] SRCADDR_SEL_B    = 3'd5;

  localparam logic [7:0] VEC_ADDR_OPCODE = 8'd253;
  localparam logic [7:0] VEC_ADDR_OVF    = 8'd254;
  localparam logic [7:0] VEC_ADDR_DIVZ   = 8'd255;

  // Mux select that addresses the vector byte belonging to a cause.
  function automatic logic [2:0] cause_to_sel(input logic [1:0] c);
    case (c)
      CAUSE_OPCODE: cause_to_sel = SRCADDR_SEL_V253;
      CAUSE_OVF:    cause_to_sel = SRCADDR_SEL_V254;
      CAUSE_DIVZ:   cause_to_sel = SRCADDR_SEL_V255;
      default:      cause_to_sel = SRCADDR_SEL_IORD;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/exc_prio_enc.sv
// ============================================================================
// Module  : exc_prio_enc
// Brief   : Exception flag priority encoder (opcode > overflow > divzero).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module exc_prio_enc
  import exc_pkg::*;
(
  input  logic       i_opcode,
  input  logic       i_overflow,
  input  logic       i_divzero,
  output logic       o_any,
  output logic [1:0] o_cause
);

  always_comb begin
    o_any   = i_opcode | i_overflow | i_divzero;
    o_cause = CAUSE_NONE;
    if (i_opcode)
      o_cause = CAUSE_OPCODE;
    else if (i_overflow)
      o_cause = CAUSE_OVF;
    else if (i_divzero)
      o_cause = CAUSE_DIVZ;
  end

endmodule

`default_nettype wire

// File: rtl/exception_ctrl.sv
// ============================================================================
// Module  : exception_ctrl
// Brief   : Exception-entry sequencer: saves EPC, fetches the vector byte and
//           loads PC. Optional cause output register: EXC_CAUSE_REG_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module exception_ctrl
  import exc_pkg::*;
#(
  parameter int          MEM_LAT = 1,
  parameter logic [31:0] EPC_OFS = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_opcode,
  input  logic        exc_overflow,
  input  logic        exc_divzero,
  input  logic [31:0] pc_in,
  input  logic [31:0] mem_data_in,
  output logic [2:0]  srcaddr_sel,
  output logic        mem_req,
  output logic [31:0] epc_out,
  output logic        epc_wr,
  output logic [31:0] pc_out,
  output logic        pc_wr,
  output logic        busy,
  output logic [1:0]  cause
);

  localparam logic [3:0] C_LAT = 4'(MEM_LAT);

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic [1:0]  r_exc_cause;
  logic [31:0] r_epc;
  logic        w_any;
  logic [1:0]  w_cause;
  logic        w_unused_data;

  assign w_unused_data = ^mem_data_in[31:8];

  exc_prio_enc u_prio (
    .i_opcode   (exc_opcode),
    .i_overflow (exc_overflow),
    .i_divzero  (exc_divzero),
    .o_any      (w_any),
    .o_cause    (w_cause)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 4'd0;
      r_exc_cause <= CAUSE_NONE;
      r_epc       <= 32'd0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_exc_cause <= w_cause;
            r_epc       <= pc_in - EPC_OFS;
          end
        end
        ST_ADDR: r_cnt <= C_LAT;
        ST_WAIT: r_cnt <= r_cnt - 4'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next      = r_state;
    srcaddr_sel = SRCADDR_SEL_IORD;
    mem_req     = 1'b0;
    epc_wr      = 1'b0;
    pc_wr       = 1'b0;
    busy        = 1'b0;
    pc_out      = 32'd0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) w_next = ST_ADDR;
      end
      ST_ADDR: begin
        srcaddr_sel = cause_to_sel(r_exc_cause);
        mem_req     = 1'b1;
        epc_wr      = 1'b1;
        busy        = 1'b1;
        w_next      = (C_LAT == 4'd0) ? ST_LOAD : ST_WAIT;
      end
      ST_WAIT: begin
        srcaddr_sel = cause_to_sel(r_exc_cause);
        mem_req     = 1'b1;
        busy        = 1'b1;
        if (r_cnt == 4'd1) w_next = ST_LOAD;
      end
      ST_LOAD: begin
        srcaddr_sel = cause_to_sel(r_exc_cause);
        pc_wr       = 1'b1;
        busy        = 1'b1;
        pc_out      = {24'd0, mem_data_in[7:0]};
        w_next      = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign epc_out = r_epc;

`ifdef EXC_CAUSE_REG_EN
  assign cause = r_exc_cause;
`else
  assign cause = CAUSE_NONE;
`endif

endmodule

`default_nettype wire

// File: tb/tb_exception_ctrl.sv
// ============================================================================
// Module  : tb_exception_ctrl
// Brief   : Self-checking bench for exception_ctrl at MEM_LAT 1, 0 and 3;
//           cause expectations follow EXC_CAUSE_REG_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_exception_ctrl;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        exc_opcode, exc_overflow, exc_divzero;
  logic [31:0] pc_in, mem_data_in;

  logic [2:0]  sel    [N];
  logic        memreq [N];
  logic [31:0] epc    [N];
  logic        epcwr  [N];
  logic [31:0] pcout  [N];
  logic        pcwr   [N];
  logic        bsy    [N];
  logic [1:0]  cse    [N];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    exception_ctrl #(
      .MEM_LAT (g == 0 ? 1 : (g == 1 ? 0 : 3)),
      .EPC_OFS (32'd4)
    ) u_dut (
      .clk          (clk),
      .reset        (reset),
      .exc_opcode   (exc_opcode),
      .exc_overflow (exc_overflow),
      .exc_divzero  (exc_divzero),
      .pc_in        (pc_in),
      .mem_data_in  (mem_data_in),
      .srcaddr_sel  (sel[g]),
      .mem_req      (memreq[g]),
      .epc_out      (epc[g]),
      .epc_wr       (epcwr[g]),
      .pc_out       (pcout[g]),
      .pc_wr        (pcwr[g]),
      .busy         (bsy[g]),
      .cause        (cse[g])
    );
  end

  // Reference: each instance is either idle (pos 0) or at step pos of a
  // 2+latency cycle sequence: step 1 saves EPC, last step writes PC.
  int          lat  [N] = '{1, 0, 3};
  int          pos  [N];
  int          mcause [N];
  logic [31:0] mepc [N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < N; k++) begin
      if (reset) begin
        pos[k] = 0; mcause[k] = 0; mepc[k] = 32'd0;
      end else if (pos[k] == 0) begin
        if (exc_opcode || exc_overflow || exc_divzero) begin
          mcause[k] = exc_opcode ? 1 : (exc_overflow ? 2 : 3);
          mepc[k]   = pc_in - 32'd4;
          pos[k]    = 1;
        end
      end else begin
        pos[k] = pos[k] + 1;
        if (pos[k] > 2 + lat[k]) pos[k] = 0;
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < N; k++) begin
      int  last;
      bit  act;
      last = 2 + lat[k];
      act  = (pos[k] != 0);
      chk($sformatf("i%0d busy", k),    32'(bsy[k]),    32'(act));
      chk($sformatf("i%0d epc_wr", k),  32'(epcwr[k]),  32'(pos[k] == 1));
      chk($sformatf("i%0d mem_req", k), 32'(memreq[k]), 32'(act && pos[k] < last));
      chk($sformatf("i%0d pc_wr", k),   32'(pcwr[k]),   32'(pos[k] == last));
      chk($sformatf("i%0d sel", k),     32'(sel[k]),    act ? 32'(mcause[k]) : 32'd0);
      chk($sformatf("i%0d pc_out", k),  pcout[k],
          (pos[k] == last) ? {24'd0, mem_data_in[7:0]} : 32'd0);
      chk($sformatf("i%0d epc_out", k), epc[k], mepc[k]);
`ifdef EXC_CAUSE_REG_EN
      chk($sformatf("i%0d cause", k),   32'(cse[k]),    32'(mcause[k]));
`else
      chk($sformatf("i%0d cause", k),   32'(cse[k]),    32'd0);
`endif
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic set_flags(input bit op, input bit ov, input bit dz);
    exc_opcode = op; exc_overflow = ov; exc_divzero = dz;
  endtask

  task automatic idle_cycles(input int n);
    set_flags(0, 0, 0);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    reset = 1'b1; set_flags(0, 0, 0);
    pc_in = 32'd0; mem_data_in = 32'd0;
    for (int k = 0; k < N; k++) begin pos[k] = 0; mcause[k] = 0; mepc[k] = 0; end
    cycle(); cycle();
    reset = 1'b0;
    idle_cycles(2);

    // overflow pulse, vector byte A7
    pc_in = 32'h0000_0104; mem_data_in = 32'h0000_00A7;
    set_flags(0, 1, 0);
    cycle();
    chk("t1 epc", epc[0], 32'h0000_0100);
    chk("t1 sel", 32'(sel[0]), 32'd2);
    set_flags(0, 0, 0);
    cycle();
    cycle();
    chk("t1 pc_wr", 32'(pcwr[0]), 32'd1);
    chk("t1 pc_out", pcout[0], 32'h0000_00A7);
    idle_cycles(6);

    // all flags together, upper data bits discarded
    mem_data_in = 32'hFFFF_FF3C;
    set_flags(1, 1, 1);
    cycle();
    chk("t2 sel", 32'(sel[0]), 32'd1);
    set_flags(0, 0, 0);
    cycle();
    cycle();
    chk("t2 pc_out", pcout[0], 32'h0000_003C);
    idle_cycles(6);

    // divzero on zero-latency instance
    set_flags(0, 0, 1);
    cycle();
    chk("t3 sel", 32'(sel[1]), 32'd3);
    set_flags(0, 0, 0);
    cycle();
    chk("t3 pc_wr", 32'(pcwr[1]), 32'd1);
    cycle();
    chk("t3 busy end", 32'(bsy[1]), 32'd0);
    idle_cycles(6);

    // reset while the latency-3 instance is waiting
    set_flags(1, 0, 0);
    cycle();
    set_flags(0, 0, 0);
    cycle(); cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("t4 sel", 32'(sel[2]), 32'd0);
    chk("t4 epc", epc[2], 32'd0);
    idle_cycles(6);

    // overflow during WAIT is ignored
    set_flags(1, 0, 0);
    cycle();
    set_flags(0, 0, 0);
    cycle();
    set_flags(0, 1, 0);
    cycle();
    set_flags(0, 0, 0);
    idle_cycles(6);

    // EPC wraps below zero
    pc_in = 32'd0;
    set_flags(1, 0, 0);
    cycle();
    chk("t6 epc", epc[0], 32'hFFFF_FFFC);
    idle_cycles(6);

    // randomized traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      set_flags(($urandom % 10) == 0, ($urandom % 10) == 0, ($urandom % 10) == 0);
      pc_in       = $urandom;
      mem_data_in = $urandom;
      reset       = (($urandom % 60) == 0);
      cycle();
    end
    reset = 1'b0;
    idle_cycles(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
